// File: rtl/logic_unit_pipe.sv
// Purpose: two-stage bitwise logic unit (8 ops) with zero/parity/popcount flags on the result.
// Latency: operands presented in cycle N appear on the outputs in cycle N+2 (S1 register, then S2 register).
// Backpressure: out_ready low freezes S2; S1 absorbs one more entry, then in_ready drops (max 2 in flight).
module logic_unit_pipe #(
  parameter int  WIDTH = 32,
  localparam int POP_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [POP_W-1:0] popcount
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NOR    = 3'd3,
    OP_ANDN   = 3'd4,
    OP_ORN    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  // Operands held in stage 1.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
  } s1_t;

  // Result and derived flags held in stage 2.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic [POP_W-1:0] popcount;
  } s2_t;

  logic             s1_vld;
  logic             s2_vld;
  logic             s2_free;
  logic             s1_move;
  logic             accept;
  s1_t              s1_dat;
  s2_t              s2_dat;
  s2_t              s2_nxt;
  logic [WIDTH-1:0] res;
  logic [POP_W-1:0] cnt;

  // Handshake: S2 frees when empty or draining, S1 moves into a free S2, input fills a free/moving S1.
  always_comb begin
    s2_free  = !s2_vld || out_ready;
    s1_move  = s1_vld && s2_free;
    in_ready = !s1_vld || s1_move;
    accept   = in_valid && in_ready;
  end

  // Evaluate the selected bitwise op on S1 contents and derive the flags for S2.
  always_comb begin
    res = '0;
    case (s1_dat.op)
      OP_AND:  res = s1_dat.a & s1_dat.b;
      OP_OR:   res = s1_dat.a | s1_dat.b;
      OP_XOR:  res = s1_dat.a ^ s1_dat.b;
      OP_NOR:  res = ~(s1_dat.a | s1_dat.b);
      OP_ANDN: res = s1_dat.a & ~s1_dat.b;
      OP_ORN:  res = s1_dat.a | ~s1_dat.b;
      OP_XNOR: res = ~(s1_dat.a ^ s1_dat.b);
      default: res = s1_dat.a;  // PASS_A: b is ignored
    endcase
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + POP_W'(res[i]);
    end
    s2_nxt.result   = res;
    s2_nxt.zero     = (res == '0);
    s2_nxt.parity   = ^res;
    s2_nxt.popcount = cnt;
  end

  // Stage valids: flush wins over any transfer in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= accept ? 1'b1 : (s1_move ? 1'b0 : s1_vld);
      s2_vld <= s1_move ? 1'b1 : (out_ready ? 1'b0 : s2_vld);
    end
  end

  // S1 operands load only on a kept accept; may reload in the same edge S1 moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dat <= '0;
    end else if (accept && !flush) begin
      s1_dat <= '{a: a, b: b, op: op_e'(op)};
    end
  end

  // S2 result/flags load only when S1 moves; otherwise hold stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_dat <= '0;
    end else if (s1_move && !flush) begin
      s2_dat <= s2_nxt;
    end
  end

  assign out_valid = s2_vld;
  assign result    = s2_dat.result;
  assign zero      = s2_dat.zero;
  assign parity    = s2_dat.parity;
  assign popcount  = s2_dat.popcount;

endmodule
